// File: rtl/alloc_pilot_demux_if.sv
// alloc_pilot_demux_if: WB-style sample stream (data, frame, strobe, write, accept).
interface alloc_pilot_demux_if #(parameter int DW = 32);
    logic [DW-1:0] dat;
    logic          cyc;
    logic          stb;
    logic          we;
    logic          ack;
    modport master (output dat, cyc, stb, we, input ack);
    modport slave  (input dat, cyc, stb, we, output ack);
endinterface

// File: rtl/alloc_pilot_demux.sv
// alloc_pilot_demux: allocation-driven subcarrier demux (data out, pilot sum, nulls dropped).
// Optional ALLOC_SHADOW_EN: VEC_LD shadow map that switches in at the next symbol boundary.
module alloc_pilot_demux #(
    parameter int NSC = 200,
    parameter int DW  = 32,
    parameter int PSW = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alloc_pilot_demux_if.slave    in_bus,
    alloc_pilot_demux_if.master   out_bus,
    input  logic [2*NSC-1:0]      alloc_vec,
    input  logic                  vec_ld,
    output logic signed [PSW-1:0] pil_re,
    output logic signed [PSW-1:0] pil_im,
    output logic                  pil_stb,
    output logic                  frm_err
);
    localparam int KW = (NSC > 1) ? $clog2(NSC) : 1;
    localparam int HW = DW / 2;

    logic [KW-1:0]         k;
    logic [2*NSC-1:0]      use_vec;
    logic [1:0]            code;
    logic                  take, load, last, pilot, abort, stb_nxt;
    logic signed [PSW-1:0] acc_re, acc_im, re_x, im_x, sum_re, sum_im;

`ifdef ALLOC_SHADOW_EN
    logic [2*NSC-1:0] shadow, active;
    logic             pending;
    // A pending map is selected combinationally at k = 0 so an idle boundary applies it to the next beat
    assign use_vec = (pending && k == '0) ? shadow : active;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            shadow  <= '1;
            active  <= '1;
            pending <= 1'b0;
        end else begin
            if (pending && k == '0) active <= shadow;
            if (vec_ld) begin
                shadow  <= alloc_vec;
                pending <= 1'b1;
            end else if (k == '0) pending <= 1'b0;
        end
`else
    logic unused_vec_ld;
    assign unused_vec_ld = vec_ld;
    assign use_vec = alloc_vec;
`endif

    assign code     = use_vec[2*k +: 2];
    assign in_bus.ack = rst_n & in_bus.cyc & in_bus.stb & in_bus.we & (~out_bus.stb | out_bus.ack);
    assign take     = in_bus.ack;
    assign load     = take & (code == 2'b11);
    assign pilot    = take & (code[0] ^ code[1]);
    assign last     = take & (k == KW'(NSC - 1));
    assign abort    = ~in_bus.cyc & (k != '0);
    assign stb_nxt  = load | (out_bus.stb & ~out_bus.ack);
    assign out_bus.we = out_bus.stb;
    assign re_x     = {{(PSW-HW){in_bus.dat[HW-1]}}, in_bus.dat[HW-1:0]};
    assign im_x     = {{(PSW-HW){in_bus.dat[DW-1]}}, in_bus.dat[DW-1:HW]};
    // Code 10 is the negated pilot, so bit 1 selects subtraction
    assign sum_re   = acc_re + (pilot ? (code[1] ? -re_x : re_x) : '0);
    assign sum_im   = acc_im + (pilot ? (code[1] ? -im_x : im_x) : '0);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            k           <= '0;
            acc_re      <= '0;
            acc_im      <= '0;
            pil_re      <= '0;
            pil_im      <= '0;
            pil_stb     <= 1'b0;
            frm_err     <= 1'b0;
            out_bus.dat <= '0;
            out_bus.stb <= 1'b0;
            out_bus.cyc <= 1'b0;
        end else begin
            out_bus.stb <= stb_nxt;
            out_bus.cyc <= load | (out_bus.cyc & (in_bus.cyc | stb_nxt));
            if (load) out_bus.dat <= in_bus.dat;
            pil_stb <= last;
            frm_err <= abort;
            k       <= (last | abort) ? '0 : take ? k + 1'b1 : k;
            acc_re  <= (last | abort) ? '0 : sum_re;
            acc_im  <= (last | abort) ? '0 : sum_im;
            if (last) begin
                pil_re <= sum_re;
                pil_im <= sum_im;
            end
        end
endmodule

// File: tb/tb_alloc_pilot_demux.sv
// tb_alloc_pilot_demux: table-driven scenarios plus reset sequences for alloc_pilot_demux.
module tb_alloc_pilot_demux;
    localparam int NSC = 200;
    localparam int DW  = 32;
    localparam int PSW = 24;

    typedef struct {
        string name;
        int    map_id;
        int    nbeats;
        bit    bp;
        int    sw_k;
        int    sw_map;
        int    exp_out;
        int    exp_pil;
        int    exp_err;
        int    exp_re;
        int    exp_im;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alloc_pilot_demux_if #(.DW(DW)) in_bus ();
    alloc_pilot_demux_if #(.DW(DW)) out_bus ();
    logic [2*NSC-1:0]      alloc_vec;
    logic                  vec_ld = 1'b0;
    logic signed [PSW-1:0] pil_re, pil_im;
    logic                  pil_stb, frm_err;

    alloc_pilot_demux #(.NSC(NSC), .DW(DW), .PSW(PSW)) dut (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .out_bus(out_bus),
        .alloc_vec(alloc_vec), .vec_ld(vec_ld),
        .pil_re(pil_re), .pil_im(pil_im), .pil_stb(pil_stb), .frm_err(frm_err)
    );

    int passed = 0, total = 0;
    int k_m = 0, s_re = 0, s_im = 0, last_re = 0, last_im = 0;
    int n_out = 0, n_pil = 0, n_err = 0;
    logic [DW-1:0] expq[$];
    logic pil_due = 1'b0, err_due = 1'b0, prev_stall = 1'b0, acc_flag = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    vec_t tbl[6];

    task automatic check(input string name, input logic ok, input longint act, input longint req);
        total++;
        if (ok === 1'b1) passed++;
        else $display("FAIL %s: got %0d want %0d", name, act, req);
    endtask

    function automatic logic [2*NSC-1:0] map_vec(input int id);
        logic [2*NSC-1:0] v;
        logic [1:0] c;
        for (int i = 0; i < NSC; i++) begin
            c = 2'b11;
            if (id == 0 && (i == 12 || i == 37 || i == 137 || i == 187)) c = 2'b01;
            if (id == 0 && (i == 62 || i == 87 || i == 112 || i == 162)) c = 2'b10;
            if (id == 1 && (i < 28 || i > 171)) c = 2'b00;
            v[2*i +: 2] = c;
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] sample(input int k);
        logic [DW/2-1:0] r, i;
        r = 16'(k);
        i = 16'(-k);
        return {i, r};
    endfunction

    task automatic accept();
        logic [1:0] c;
        c = alloc_vec[2*k_m +: 2];
        if (c == 2'b11) expq.push_back(sample(k_m));
        if (c == 2'b01) begin s_re += k_m; s_im -= k_m; end
        if (c == 2'b10) begin s_re -= k_m; s_im += k_m; end
        if (k_m == NSC - 1) begin
            pil_due = 1'b1;
            last_re = s_re;
            last_im = s_im;
            s_re = 0;
            s_im = 0;
            k_m = 0;
        end else k_m++;
    endtask

    task automatic step(input logic cyc, input logic stb, input logic ack_i, input logic [DW-1:0] d);
        logic [DW-1:0] e;
        @(negedge clk);
        if (prev_stall) check("stall_hold", out_bus.stb === 1'b1 && out_bus.dat === prev_dat, out_bus.dat, prev_dat);
        if (pil_stb || pil_due) begin
            check("pil_stb", pil_stb === pil_due, pil_stb, pil_due);
            if (pil_due) begin
                check("pil_re", int'(pil_re) == last_re, int'(pil_re), last_re);
                check("pil_im", int'(pil_im) == last_im, int'(pil_im), last_im);
            end
        end
        if (frm_err || err_due) check("frm_err", frm_err === err_due, frm_err, err_due);
        n_pil += int'(pil_stb);
        n_err += int'(frm_err);
        pil_due = 1'b0;
        err_due = 1'b0;
        in_bus.cyc = cyc;
        in_bus.stb = stb;
        in_bus.we  = stb;
        in_bus.dat = d;
        out_bus.ack = ack_i;
        if (!cyc && k_m != 0) begin
            err_due = 1'b1;
            k_m = 0;
            s_re = 0;
            s_im = 0;
        end
        #1;
        if (out_bus.stb && ack_i) begin
            n_out++;
            if (expq.size() == 0) check("extra_out", 1'b0, out_bus.dat, 0);
            else begin
                e = expq.pop_front();
                check("dat", out_bus.dat === e, out_bus.dat, e);
            end
        end
        prev_stall = out_bus.stb && !ack_i;
        prev_dat = out_bus.dat;
        acc_flag = in_bus.ack;
        if (acc_flag) accept();
    endtask

    task automatic run(input vec_t v);
        int j, guard;
        logic t;
        alloc_vec = map_vec(v.map_id);
        n_out = 0; n_pil = 0; n_err = 0;
        j = 0; guard = 0; t = 1'b1;
        while (j < v.nbeats && guard < 2000) begin
            if (v.sw_k >= 0 && j >= v.sw_k) alloc_vec = map_vec(v.sw_map);
            step(1'b1, 1'b1, v.bp ? t : 1'b1, sample(k_m));
            t = ~t;
            if (acc_flag) j++;
            guard++;
        end
        if (guard >= 2000) check({v.name, "_timeout"}, 1'b0, j, v.nbeats);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, '0);
        check({v.name, "_outs"}, n_out == v.exp_out, n_out, v.exp_out);
        check({v.name, "_pils"}, n_pil == v.exp_pil, n_pil, v.exp_pil);
        check({v.name, "_errs"}, n_err == v.exp_err, n_err, v.exp_err);
        check({v.name, "_re"}, int'(pil_re) == v.exp_re, int'(pil_re), v.exp_re);
        check({v.name, "_im"}, int'(pil_im) == v.exp_im, int'(pil_im), v.exp_im);
        check({v.name, "_cyc_o"}, out_bus.cyc === 1'b0, out_bus.cyc, 0);
        check({v.name, "_left"}, expq.size() == 0, expq.size(), 0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_stb"}, out_bus.stb === 1'b0, out_bus.stb, 0);
        check({tag, "_cyc"}, out_bus.cyc === 1'b0, out_bus.cyc, 0);
        check({tag, "_pil_stb"}, pil_stb === 1'b0, pil_stb, 0);
        check({tag, "_frm_err"}, frm_err === 1'b0, frm_err, 0);
        check({tag, "_ack"}, in_bus.ack === 1'b0, in_bus.ack, 0);
        check({tag, "_dat"}, out_bus.dat === '0, out_bus.dat, 0);
        check({tag, "_pil_re"}, pil_re === '0, pil_re, 0);
    endtask

    initial begin
        tbl[0] = '{"symbol",   0, 200, 1'b0, -1, 0, 192, 1, 0,  -50,  50};
        tbl[1] = '{"backpr",   0, 400, 1'b1, -1, 0, 384, 2, 0,  -50,  50};
        tbl[2] = '{"abort",    0,  50, 1'b0, -1, 0,  48, 0, 1,  -50,  50};
        tbl[3] = '{"restart",  0, 200, 1'b0, -1, 0, 192, 1, 0,  -50,  50};
        tbl[4] = '{"nulls",    1, 200, 1'b0, -1, 0, 144, 1, 0,    0,   0};
        tbl[5] = '{"live_chg", 0, 200, 1'b0, 100, 2, 196, 1, 0, -100, 100};
        in_bus.cyc = 1'b1; in_bus.stb = 1'b1; in_bus.we = 1'b1; in_bus.dat = '0;
        out_bus.ack = 1'b1;
        alloc_vec = map_vec(0);
        repeat (3) @(negedge clk);
        reset_checks("por");
        in_bus.cyc = 1'b0; in_bus.stb = 1'b0; in_bus.we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) run(tbl[i]);
        // Reset in the middle of a symbol with a stalled output beat pending
        alloc_vec = map_vec(0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, sample(k_m));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, sample(k_m));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        k_m = 0; s_re = 0; s_im = 0;
        expq.delete();
        prev_stall = 1'b0; pil_due = 1'b0; err_due = 1'b0;
        in_bus.cyc = 1'b0; in_bus.stb = 1'b0; in_bus.we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(tbl[0]);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
